mp3_frame_sync: RTL
===================

Name: mp3_frame_sync

Overview:
- Byte-stream front end that sits directly upstream of the side-info parser.
- Hunts for MPEG-1 Layer III frame sync and validates and decodes the 4-byte frame header.
- Computes frame length and strips the optional 2-byte CRC.
- Re-emits the frame body with a frame-relative byte counter, so side info always appears at counter 4..35 (stereo) or 4..20 (mono).

Parameters:
- CNT_W, 32, width of byte_count (matches the downstream counter input)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- axiid  in  8  input byte
- axiiv  in  1  input byte valid
- axiod  out  8  body byte (registered copy of axiid)
- axiov  out  1  body byte valid
- byte_count  out  CNT_W  frame-relative index of axiod; first body byte = 4
- frame_start  out  1  one-cycle pulse on the cycle the header is accepted
- protection_bit  out  1  header bit; 0 means CRC present
- bitrate_index  out  4  header field
- sampling_freq  out  2  header field
- padding_bit  out  1  header field
- mode  out  2  header field; 11 = mono
- mode_ext  out  2  header field
- frame_len  out  11  total frame bytes, including header and CRC
- sync_err  out  1  one-cycle pulse when an expected header fails validation

Behaviour:
- Reset values: all outputs 0; state HUNT. Reset mid-frame aborts the frame with no further axiov.
- All state advances only on cycles with axiiv=1. Cycles with axiiv=0 hold state; axiov is 0 on those cycles.
- Output latency: axiod/axiov/byte_count are registered, 1 cycle after the accepted input byte.
- HUNT: wait for 0xFF, then go to HDR1.
- HDR1: byte[7:1] must equal 7'b1111101 (ID=1, layer=01); bit0 gives protection_bit.
  - On pass, go to HDR2.
  - On fail, if the byte is 0xFF stay in HDR1 (new candidate), else go to HUNT.
- HDR2: bitrate_index = byte[7:4], sampling_freq = byte[3:2], padding_bit = byte[1].
  - Reject if bitrate_index is 0 or 15, or sampling_freq is 3.
  - On reject, apply the same 0xFF rule as HDR1.
- HDR3: mode = byte[7:6], mode_ext = byte[5:4]. Always accepted.
  - Latch all header fields and frame_len, pulse frame_start.
  - Load remain = frame_len - 4 - (protection_bit ? 0 : 2).
  - Go to CRC if protection_bit = 0, else go to BODY.
- CRC: consume 2 bytes with no axiov and no byte_count increment, then go to BODY.
- BODY: each byte is emitted with axiov=1. byte_count starts at 4 and increments per emitted byte. remain decrements.
  - After the byte where remain reaches 1, go to NEXT0.
  - remain = 0 on entry cannot occur (minimum frame_len is 96).
- NEXT0/NEXT1/NEXT2/NEXT3: expect the next header back-to-back, with the same checks as HUNT/HDR1/HDR2/HDR3.
  - Any failure pulses sync_err once and returns to HUNT. A failing byte of 0xFF goes to HDR1 instead of HUNT.
- Header fields and frame_len stay stable from frame_start until the next frame_start.
- frame_len = floor(144 * bitrate_kbps * 1000 / fs) + padding_bit, taken from a 14x3 ROM of base lengths (no multiplier in RTL). The padding add is 11-bit.
- Free-format (bitrate_index 0) is unsupported and is rejected.

Decomposition:
- Package mp3_pkg holds:
  - state enum
  - MP3_SYNC_BYTE, HDR_BYTES=4, CRC_BYTES=2
  - bitrate table (kbps, MPEG-1 L3)
  - sample-rate table
  - base frame-length ROM constant array
- One sub-module, mp3_frame_len_rom: combinational lookup {bitrate_index, sampling_freq, padding_bit} -> frame_len.

Test Plan:
- Stream FF FB 90 64 followed by 413 body bytes:
  - frame_start 1 cycle after 0x64; frame_len=417, protection_bit=1, mode=01.
  - axiov for exactly 413 bytes, byte_count 4..416.
- FF FB 92 C0 (padding, mono):
  - frame_len=418, mode=11.
  - 414 body bytes emitted; the 17 side-info bytes appear at byte_count 4..20.
- FF FA 90 64 + CRC AB CD + body:
  - AB/CD never emitted; first emitted byte is the one after CD, with byte_count=4.
  - 411 bytes emitted.
- Garbage 00 FF FF FB 90 64:
  - locks on the second FF; frame_start asserted.
  - Variant with FF FB F0 (bitrate 15): rejected, returns to HUNT, no frame_start.
- Two frames back-to-back, second header corrupted to FF 00:
  - sync_err pulses once, state returns to HUNT.
  - Re-sync occurs on a later valid header.
- Reset asserted mid-BODY, and axiiv gaps of 3 cycles:
  - reset: all outputs 0 next cycle and HUNT is resumed.
  - gaps: byte_count is unaffected by idle cycles.

Source files
------------

// File: rtl/mp3_pkg.sv
// mp3_pkg: shared states, header constants and MPEG-1 Layer III rate/length tables
package mp3_pkg;
    typedef enum logic [3:0] {
        HUNT, HDR1, HDR2, HDR3, CRC_HI, CRC_LO, BODY, NEXT0, NEXT1, NEXT2, NEXT3
    } state_t;
    localparam logic [7:0] MP3_SYNC_BYTE = 8'hFF;
    localparam logic [6:0] HDR1_PATTERN = 7'b1111101;
    localparam int HDR_BYTES = 4;
    localparam int CRC_BYTES = 2;
    localparam int BITRATE_KBPS [16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128, 160, 192, 224, 256, 320, 0};
    localparam int SAMPLE_RATE_HZ [4] = '{44100, 48000, 32000, 0};
    localparam logic [10:0] BASE_LEN [14][3] = '{
        '{11'd104,  11'd96,   11'd144},
        '{11'd130,  11'd120,  11'd180},
        '{11'd156,  11'd144,  11'd216},
        '{11'd182,  11'd168,  11'd252},
        '{11'd208,  11'd192,  11'd288},
        '{11'd261,  11'd240,  11'd360},
        '{11'd313,  11'd288,  11'd432},
        '{11'd365,  11'd336,  11'd504},
        '{11'd417,  11'd384,  11'd576},
        '{11'd522,  11'd480,  11'd720},
        '{11'd626,  11'd576,  11'd864},
        '{11'd731,  11'd672,  11'd1008},
        '{11'd835,  11'd768,  11'd1152},
        '{11'd1044, 11'd960,  11'd1440}
    };
endpackage

// File: rtl/mp3_frame_sync_if.sv
// mp3_frame_sync_if: byte stream in, frame body and decoded header out
interface mp3_frame_sync_if #(
    parameter int CNT_W = 32
);
    logic [7:0]       axiid;
    logic             axiiv;
    logic [7:0]       axiod;
    logic             axiov;
    logic [CNT_W-1:0] byte_count;
    logic             frame_start;
    logic             protection_bit;
    logic [3:0]       bitrate_index;
    logic [1:0]       sampling_freq;
    logic             padding_bit;
    logic [1:0]       mode;
    logic [1:0]       mode_ext;
    logic [10:0]      frame_len;
    logic             sync_err;
    modport slave (
        input  axiid, axiiv,
        output axiod, axiov, byte_count, frame_start, protection_bit, bitrate_index,
               sampling_freq, padding_bit, mode, mode_ext, frame_len, sync_err
    );
    modport master (
        output axiid, axiiv,
        input  axiod, axiov, byte_count, frame_start, protection_bit, bitrate_index,
               sampling_freq, padding_bit, mode, mode_ext, frame_len, sync_err
    );
endinterface

// File: rtl/mp3_frame_len_rom.sv
// mp3_frame_len_rom: {bitrate_index, sampling_freq, padding_bit} -> frame length, 0 when invalid
module mp3_frame_len_rom
    import mp3_pkg::*;
(
    input  logic [3:0]  bitrate_index,
    input  logic [1:0]  sampling_freq,
    input  logic        padding_bit,
    output logic [10:0] frame_len
);
    logic       valid;
    logic [3:0] br_i;
    logic [1:0] fs_i;
    always_comb begin
        valid     = bitrate_index != 4'd0 && bitrate_index != 4'd15 && sampling_freq != 2'd3;
        br_i      = valid ? bitrate_index - 4'd1 : 4'd0;
        fs_i      = valid ? sampling_freq : 2'd0;
        frame_len = valid ? BASE_LEN[br_i][fs_i] + {10'd0, padding_bit} : 11'd0;
    end
endmodule

// File: rtl/mp3_frame_sync.sv
// mp3_frame_sync: MPEG-1 Layer III sync hunter, header decoder, CRC stripper and body re-emitter
module mp3_frame_sync
    import mp3_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic             clk,
    input logic             rst,
    mp3_frame_sync_if.slave s
);
    state_t           state, state_n;
    logic             h_prot, h_pad;
    logic [3:0]       h_br;
    logic [1:0]       h_fs;
    logic [10:0]      rom_len, remain;
    logic [CNT_W-1:0] idx;
    logic             accept, err, is_sync, hdr1_ok, hdr2_ok, body_byte;

    assign is_sync   = s.axiid == MP3_SYNC_BYTE;
    assign hdr1_ok   = s.axiid[7:1] == HDR1_PATTERN;
    assign hdr2_ok   = s.axiid[7:4] != 4'd0 && s.axiid[7:4] != 4'd15 && s.axiid[3:2] != 2'd3;
    assign body_byte = s.axiiv && state == BODY;

    mp3_frame_len_rom u_rom (
        .bitrate_index(h_br),
        .sampling_freq(h_fs),
        .padding_bit  (h_pad),
        .frame_len    (rom_len)
    );

    always_ff @(posedge clk) state <= rst ? HUNT : state_n;

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        err     = 1'b0;
        if (s.axiiv) begin
            case (state)
                HUNT:   state_n = is_sync ? HDR1 : HUNT;
                HDR1:   state_n = hdr1_ok ? HDR2 : is_sync ? HDR1 : HUNT;
                HDR2:   state_n = hdr2_ok ? HDR3 : is_sync ? HDR1 : HUNT;
                HDR3, NEXT3: begin
                    accept  = 1'b1;
                    state_n = h_prot ? BODY : CRC_HI;
                end
                CRC_HI: state_n = CRC_LO;
                CRC_LO: state_n = BODY;
                BODY:   state_n = remain == 11'd1 ? NEXT0 : BODY;
                NEXT0: begin
                    err     = !is_sync;
                    state_n = is_sync ? NEXT1 : HUNT;
                end
                NEXT1: begin
                    err     = !hdr1_ok;
                    state_n = hdr1_ok ? NEXT2 : is_sync ? HDR1 : HUNT;
                end
                NEXT2: begin
                    err     = !hdr2_ok;
                    state_n = hdr2_ok ? NEXT3 : is_sync ? HDR1 : HUNT;
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s.axiod          <= '0;
            s.axiov          <= 1'b0;
            s.byte_count     <= '0;
            s.frame_start    <= 1'b0;
            s.protection_bit <= 1'b0;
            s.bitrate_index  <= '0;
            s.sampling_freq  <= '0;
            s.padding_bit    <= 1'b0;
            s.mode           <= '0;
            s.mode_ext       <= '0;
            s.frame_len      <= '0;
            s.sync_err       <= 1'b0;
            h_prot           <= 1'b0;
            h_br             <= '0;
            h_fs             <= '0;
            h_pad            <= 1'b0;
            remain           <= '0;
            idx              <= '0;
        end else begin
            s.axiod       <= s.axiid;
            s.axiov       <= body_byte;
            s.frame_start <= accept;
            s.sync_err    <= err;
            if (s.axiiv && (state == HDR1 || state == NEXT1))
                h_prot <= s.axiid[0];
            if (s.axiiv && (state == HDR2 || state == NEXT2))
                {h_br, h_fs, h_pad} <= s.axiid[7:1];
            if (accept) begin
                s.protection_bit <= h_prot;
                s.bitrate_index  <= h_br;
                s.sampling_freq  <= h_fs;
                s.padding_bit    <= h_pad;
                s.mode           <= s.axiid[7:6];
                s.mode_ext       <= s.axiid[5:4];
                s.frame_len      <= rom_len;
                remain           <= rom_len - 11'(HDR_BYTES) - (h_prot ? 11'd0 : 11'(CRC_BYTES));
                idx              <= CNT_W'(HDR_BYTES);
            end
            if (body_byte) begin
                s.byte_count <= idx;
                idx          <= idx + 1'b1;
                remain       <= remain - 11'd1;
            end
        end
    end
endmodule
